// File: rtl/vram_arbiter.sv
// Purpose : single-port VRAM front end; video fetches win the RAM, CPU writes queue in a FIFO and drain into idle cycles.
// Latency : fetch sampled at edge T -> vram_dout valid after edge T+2; queued write reaches RAM one edge after acceptance at the earliest.
// Backpr. : cpu_ready low while the FIFO is full; a write offered while full is dropped and latches ovf until reset.
//
// Ports:
//   clk_sys, nRESET              clock, asynchronous active-low reset
//   ce_7mn, vram_addr, vram_dout video fetch slot strobe, fetch address, registered fetched byte
//   cpu_wr, cpu_addr, cpu_din    CPU write strobe/address/data
//   cpu_ready, ovf               FIFO not full, sticky dropped-write flag
//   mem_addr, mem_dout, mem_we   registered RAM address / write data / write enable
//   mem_din                      RAM read data, valid one clock after the address
module vram_arbiter #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk_sys,
   input  logic        nRESET,
   input  logic        ce_7mn,
   input  logic [14:0] vram_addr,
   output logic [7:0]  vram_dout,
   input  logic        cpu_wr,
   input  logic [14:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic        cpu_ready,
   output logic        ovf,
   output logic [14:0] mem_addr,
   output logic [7:0]  mem_dout,
   output logic        mem_we,
   input  logic [7:0]  mem_din
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_RD_ISSUE   = 2'd1,
      ST_RD_CAPTURE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // write FIFO storage and bookkeeping
   logic [FIFO_DEPTH-1:0][14:0] fifo_addr_q, fifo_addr_d;
   logic [FIFO_DEPTH-1:0][7:0]  fifo_dat_q,  fifo_dat_d;
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]            count_q,  count_d;

   // read address captured at the fetch edge; mem_addr is reused by the drain
   // before the data comes back, so forwarding needs its own copy
   logic [14:0] rd_addr_q, rd_addr_d;

   logic [7:0]  vram_dout_q, vram_dout_d;
   logic [14:0] mem_addr_q,  mem_addr_d;
   logic [7:0]  mem_dout_q,  mem_dout_d;
   logic        mem_we_q,    mem_we_d;
   logic        ovf_q,       ovf_d;

   logic             take_read;
   logic             push;
   logic             pop;
   logic [7:0]       fwd_dat;
   logic [PTR_W-1:0] idx;

   assign cpu_ready = (count_q != FULL_CNT);
   assign push      = cpu_wr && cpu_ready;
   // a fetch is only accepted from IDLE; strobes during a read are ignored
   assign take_read = (state_q == ST_IDLE) && ce_7mn;
   // every cycle except the fetch edge is a drain opportunity
   assign pop       = !take_read && (count_q != '0);

   // Forwarding source for the capture edge. Candidates are scanned from
   // oldest to youngest so the last match wins: the pending RAM write first,
   // then FIFO entries from head towards tail.
   always_comb begin
      fwd_dat = mem_din;
      idx     = '0;
      if (mem_we_q && (mem_addr_q == rd_addr_q)) begin
         fwd_dat = mem_dout_q;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (fifo_addr_q[idx] == rd_addr_q)) begin
            fwd_dat = fifo_dat_q[idx];
         end
      end
   end

   // next-state and datapath
   always_comb begin
      state_d     = state_q;
      fifo_addr_d = fifo_addr_q;
      fifo_dat_d  = fifo_dat_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rd_addr_d   = rd_addr_q;
      vram_dout_d = vram_dout_q;
      mem_addr_d  = mem_addr_q;
      mem_dout_d  = mem_dout_q;
      mem_we_d    = mem_we_q;
      ovf_d       = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (ce_7mn) begin
               state_d = ST_RD_ISSUE;
            end
         end
         ST_RD_ISSUE: begin
            state_d = ST_RD_CAPTURE;
         end
         ST_RD_CAPTURE: begin
            vram_dout_d = fwd_dat;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // RAM port: fetch address, FIFO head, or nothing
      if (take_read) begin
         mem_addr_d = vram_addr;
         mem_we_d   = 1'b0;
         rd_addr_d  = vram_addr;
      end else if (pop) begin
         mem_we_d   = 1'b1;
         mem_addr_d = fifo_addr_q[rd_ptr_q];
         mem_dout_d = fifo_dat_q[rd_ptr_q];
      end else begin
         mem_we_d   = 1'b0;
      end

      if (push) begin
         fifo_addr_d[wr_ptr_q] = cpu_addr;
         fifo_dat_d[wr_ptr_q]  = cpu_din;
         wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // readiness comes from the pre-edge count, so a pop on the same edge
      // does not rescue a write offered while full
      if (cpu_wr && !cpu_ready) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         state_q     <= ST_IDLE;
         fifo_addr_q <= '0;
         fifo_dat_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rd_addr_q   <= '0;
         vram_dout_q <= '0;
         mem_addr_q  <= '0;
         mem_dout_q  <= '0;
         mem_we_q    <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fifo_addr_q <= fifo_addr_d;
         fifo_dat_q  <= fifo_dat_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_addr_q   <= rd_addr_d;
         vram_dout_q <= vram_dout_d;
         mem_addr_q  <= mem_addr_d;
         mem_dout_q  <= mem_dout_d;
         mem_we_q    <= mem_we_d;
         ovf_q       <= ovf_d;
      end
   end

   assign vram_dout = vram_dout_q;
   assign mem_addr  = mem_addr_q;
   assign mem_dout  = mem_dout_q;
   assign mem_we    = mem_we_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Purpose : directed bench for vram_arbiter with a behavioural single-port RAM.
// Latency : inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpr. : n/a.
module tb_vram_arbiter;

   logic        clk_sys = 1'b0;
   logic        nRESET;
   logic        ce_7mn;
   logic [14:0] vram_addr;
   logic [7:0]  vram_dout;
   logic        cpu_wr;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        cpu_ready;
   logic        ovf;
   logic [14:0] mem_addr;
   logic [7:0]  mem_dout;
   logic        mem_we;
   logic [7:0]  mem_din;

   always #5 clk_sys = ~clk_sys;

   vram_arbiter #(.FIFO_DEPTH(4)) dut (
      .clk_sys   (clk_sys),
      .nRESET    (nRESET),
      .ce_7mn    (ce_7mn),
      .vram_addr (vram_addr),
      .vram_dout (vram_dout),
      .cpu_wr    (cpu_wr),
      .cpu_addr  (cpu_addr),
      .cpu_din   (cpu_din),
      .cpu_ready (cpu_ready),
      .ovf       (ovf),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .mem_we    (mem_we),
      .mem_din   (mem_din)
   );

   // synchronous single-port RAM, read-first, plus a bench-side preload port
   logic [7:0]  ram [0:32767];
   logic        pre_we = 1'b0;
   logic [14:0] pre_addr = '0;
   logic [7:0]  pre_dat = '0;

   always @(posedge clk_sys) begin
      if (pre_we) ram[pre_addr] <= pre_dat;
      else if (mem_we) ram[mem_addr] <= mem_dout;
      mem_din <= ram[mem_addr];
   end

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        pre;
      logic [14:0] pa;
      logic [7:0]  pd;
      logic        wr;
      logic [14:0] wa;
      logic [7:0]  wd;
      logic [14:0] ra;
      logic [7:0]  exp_dout;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
      end
   endtask

   // drive one clock of inputs, return on the following falling edge
   task automatic step(input logic wr, input logic [14:0] wa, input logic [7:0] wd,
                       input logic ce, input logic [14:0] va);
      cpu_wr    = wr;
      cpu_addr  = wa;
      cpu_din   = wd;
      ce_7mn    = ce;
      vram_addr = va;
      @(negedge clk_sys);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic preload(input logic [14:0] a, input logic [7:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_dat  = d;
      idle(1);
      pre_we   = 1'b0;
   endtask

   task automatic do_read(input string nm, input logic [14:0] a, input logic [7:0] exp_v);
      step(1'b0, '0, '0, 1'b1, a);
      idle(2);
      chk(nm, {24'h0, vram_dout}, {24'h0, exp_v});
   endtask

   initial begin
      logic        we_seen;
      logic [14:0] a;
      logic [7:0]  d;

      //            pre   pa        pd     wr    wa        wd     ra        exp
      vecs[0] = '{1'b1, 15'h2000, 8'h5C, 1'b0, 15'h0000, 8'h00, 15'h2000, 8'h5C};
      vecs[1] = '{1'b0, 15'h0000, 8'h00, 1'b1, 15'h0123, 8'hAA, 15'h0123, 8'hAA};
      vecs[2] = '{1'b0, 15'h0000, 8'h00, 1'b1, 15'h4123, 8'h3C, 15'h0123, 8'hAA};
      vecs[3] = '{1'b0, 15'h0000, 8'h00, 1'b0, 15'h0000, 8'h00, 15'h4123, 8'h3C};
      vecs[4] = '{1'b0, 15'h0000, 8'h00, 1'b1, 15'h7FFF, 8'hE1, 15'h7FFF, 8'hE1};
      vecs[5] = '{1'b1, 15'h0000, 8'h9D, 1'b1, 15'h0001, 8'h77, 15'h0000, 8'h9D};

      nRESET    = 1'b0;
      cpu_wr    = 1'b0;
      cpu_addr  = '0;
      cpu_din   = '0;
      ce_7mn    = 1'b0;
      vram_addr = '0;
      repeat (2) @(negedge clk_sys);

      chk("rst_vram_dout", {24'h0, vram_dout}, 32'h0);
      chk("rst_mem_addr",  {17'h0, mem_addr},  32'h0);
      chk("rst_mem_dout",  {24'h0, mem_dout},  32'h0);
      chk("rst_mem_we",    {31'h0, mem_we},    32'h0);
      chk("rst_cpu_ready", {31'h0, cpu_ready}, 32'h1);
      chk("rst_ovf",       {31'h0, ovf},       32'h0);
      nRESET = 1'b1;
      idle(1);

      // plain fetch, FIFO empty, RAM must never see a write
      preload(15'h1800, 8'h47);
      we_seen = 1'b0;
      step(1'b0, '0, '0, 1'b1, 15'h1800);
      we_seen |= mem_we;
      idle(1);
      we_seen |= mem_we;
      idle(1);
      we_seen |= mem_we;
      chk("read_1800", {24'h0, vram_dout}, 32'h47);
      chk("read_no_we", {31'h0, we_seen}, 32'h0);

      // table: optional write accepted on the fetch edge, result after T+2
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].pre) preload(vecs[i].pa, vecs[i].pd);
         step(vecs[i].wr, vecs[i].wa, vecs[i].wd, 1'b1, vecs[i].ra);
         idle(2);
         chk($sformatf("vec%0d_dout", i), {24'h0, vram_dout}, {24'h0, vecs[i].exp_dout});
         idle(2);
      end
      chk("ram_0123", {24'h0, ram[15'h0123]}, 32'hAA);
      chk("ram_4123", {24'h0, ram[15'h4123]}, 32'h3C);
      chk("ram_0001", {24'h0, ram[15'h0001]}, 32'h77);

      // three back-to-back writes to one address, then a fetch of it
      step(1'b1, 15'h0010, 8'h11, 1'b0, '0);
      step(1'b1, 15'h0010, 8'h22, 1'b0, '0);
      step(1'b1, 15'h0010, 8'h33, 1'b0, '0);
      do_read("same_addr_dout", 15'h0010, 8'h33);
      idle(3);
      chk("same_addr_ram", {24'h0, ram[15'h0010]}, 32'h33);

      // visibility window: writes at T and T+1 seen (youngest wins), T+2 not
      preload(15'h0020, 8'h01);
      step(1'b1, 15'h0020, 8'h44, 1'b1, 15'h0020);
      step(1'b1, 15'h0020, 8'h55, 1'b0, '0);
      step(1'b1, 15'h0020, 8'h66, 1'b0, '0);
      chk("vis_window", {24'h0, vram_dout}, 32'h55);
      idle(3);
      chk("vis_ram", {24'h0, ram[15'h0020]}, 32'h66);
      do_read("vis_reread", 15'h0020, 8'h66);

      // fetch strobes on consecutive clocks: second one ignored
      preload(15'h0000, 8'h12);
      preload(15'h0001, 8'h34);
      step(1'b0, '0, '0, 1'b1, 15'h0000);
      step(1'b0, '0, '0, 1'b1, 15'h0001);
      idle(1);
      chk("ce_pair_first", {24'h0, vram_dout}, 32'h12);
      idle(2);
      chk("ce_pair_ignored", {24'h0, vram_dout}, 32'h12);

      // fill the FIFO: one write per clock, fetch every 3rd clock
      preload(15'h010A, 8'h5A);
      for (int k = 0; k < 12; k++) begin
         a = 15'h0100 + 15'(k);
         d = 8'hB0 + 8'(k);
         step(1'b1, a, d, (k % 3) == 0, 15'h3000);
         if (k == 8) chk("ovf_ready_k8", {31'h0, cpu_ready}, 32'h1);
         if (k == 9) begin
            chk("ovf_full_k9", {31'h0, cpu_ready}, 32'h0);
            chk("ovf_clear_k9", {31'h0, ovf}, 32'h0);
         end
         if (k == 10) begin
            chk("ovf_set_k10", {31'h0, ovf}, 32'h1);
            chk("ovf_ready_k10", {31'h0, cpu_ready}, 32'h1);
         end
      end
      idle(6);
      chk("ovf_ram_100", {24'h0, ram[15'h0100]}, 32'hB0);
      chk("ovf_ram_109", {24'h0, ram[15'h0109]}, 32'hB9);
      chk("ovf_ram_10a", {24'h0, ram[15'h010A]}, 32'h5A);
      chk("ovf_ram_10b", {24'h0, ram[15'h010B]}, 32'hBB);
      chk("ovf_sticky",  {31'h0, ovf}, 32'h1);

      // reset during RD_ISSUE with three writes queued
      preload(15'h3000, 8'hC7);
      preload(15'h0204, 8'hEE);
      preload(15'h0205, 8'hEE);
      preload(15'h0206, 8'hEE);
      for (int k = 0; k < 7; k++) begin
         a = 15'h0200 + 15'(k);
         d = 8'hC0 + 8'(k);
         step(1'b1, a, d, (k % 3) == 0, 15'h3000);
      end
      chk("pre_reset_dout", {24'h0, vram_dout}, 32'hC7);
      nRESET = 1'b0;
      cpu_wr = 1'b0;
      ce_7mn = 1'b0;
      #1;
      chk("mid_rst_vram_dout", {24'h0, vram_dout}, 32'h0);
      chk("mid_rst_mem_addr",  {17'h0, mem_addr},  32'h0);
      chk("mid_rst_mem_dout",  {24'h0, mem_dout},  32'h0);
      chk("mid_rst_mem_we",    {31'h0, mem_we},    32'h0);
      chk("mid_rst_cpu_ready", {31'h0, cpu_ready}, 32'h1);
      chk("mid_rst_ovf",       {31'h0, ovf},       32'h0);
      @(negedge clk_sys);
      nRESET = 1'b1;
      idle(6);
      chk("rst_ram_203", {24'h0, ram[15'h0203]}, 32'hC3);
      chk("rst_ram_204", {24'h0, ram[15'h0204]}, 32'hEE);
      chk("rst_ram_205", {24'h0, ram[15'h0205]}, 32'hEE);
      chk("rst_ram_206", {24'h0, ram[15'h0206]}, 32'hEE);
      chk("rst_after_we", {31'h0, mem_we}, 32'h0);
      do_read("rst_after_read", 15'h3000, 8'hC7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
